flow_rmw_engine: RTL and testbench

Client-side read-modify-write engine for the flow RAM: accepts per-packet flow update requests, issues reads to the SRAM interface block, matches the in-order read returns to pending requests, updates the flow record (packet and byte counters), and writes it back. It sits between the flow-lookup pipeline and the SRAM interface, and sustains one update per cycle when read latency is covered by the slot count.

---
 rtl/flow_rmw_pkg.sv | 32 +++
 rtl/flow_rmw_slot_table.sv | 83 ++++++++
 rtl/flow_rmw_engine.sv | 99 +++++++++
 tb/tb_flow_rmw_engine.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_rmw_pkg.sv
// Shared widths, slot states and the saturating flow-record update for the
// flow RAM read-modify-write engine.
package flow_rmw_pkg;

    localparam int FLOW_RAM_ADDR_WIDTH  = 8;
    localparam int FLOW_RAM_WORD_WIDTH  = 64;
    localparam int FLOW_PKT_COUNT_WIDTH = FLOW_RAM_WORD_WIDTH / 2;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_READ_WAIT,
        SLOT_WB_WAIT
    } slot_state_t;

    // Record layout: {byte_count, packet_count}; both halves saturate independently.
    function automatic logic [FLOW_RAM_WORD_WIDTH-1:0] flow_update(
        input logic [FLOW_RAM_WORD_WIDTH-1:0]  word,
        input logic [FLOW_PKT_COUNT_WIDTH-1:0] add_bytes
    );
        logic [FLOW_PKT_COUNT_WIDTH:0]       pkt_sum;
        logic [FLOW_PKT_COUNT_WIDTH:0]       byte_sum;
        logic [FLOW_RAM_WORD_WIDTH-1:0]      result;
        pkt_sum  = {1'b0, word[FLOW_PKT_COUNT_WIDTH-1:0]} + 1'b1;
        byte_sum = {1'b0, word[FLOW_RAM_WORD_WIDTH-1:FLOW_PKT_COUNT_WIDTH]} + {1'b0, add_bytes};
        result[FLOW_PKT_COUNT_WIDTH-1:0] =
            pkt_sum[FLOW_PKT_COUNT_WIDTH] ? '1 : pkt_sum[FLOW_PKT_COUNT_WIDTH-1:0];
        result[FLOW_RAM_WORD_WIDTH-1:FLOW_PKT_COUNT_WIDTH] =
            byte_sum[FLOW_PKT_COUNT_WIDTH] ? '1 : byte_sum[FLOW_PKT_COUNT_WIDTH-1:0];
        return result;
    endfunction

endpackage

// File: rtl/flow_rmw_slot_table.sv
// In-order slot ring for in-flight updates: alloc, return and write-back
// pointers, occupancy count and the address hazard compare.
module flow_rmw_slot_table
    import flow_rmw_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int BYTES_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alloc,
    input  logic [FLOW_RAM_ADDR_WIDTH-1:0] alloc_addr,
    input  logic [BYTES_WIDTH-1:0]         alloc_bytes,
    input  logic                           fill,
    input  logic [FLOW_RAM_WORD_WIDTH-1:0] fill_data,
    input  logic                           free_slot,
    input  logic [FLOW_RAM_ADDR_WIDTH-1:0] probe_addr,
    output logic                           hazard,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           ret_pending,
    output logic [FLOW_RAM_ADDR_WIDTH-1:0] ret_addr,
    output logic [BYTES_WIDTH-1:0]         ret_bytes,
    output logic                           wb_pending,
    output logic [FLOW_RAM_ADDR_WIDTH-1:0] wb_addr,
    output logic [FLOW_RAM_WORD_WIDTH-1:0] wb_data
);

    localparam int PW = $clog2(DEPTH);

    slot_state_t                    state [DEPTH];
    logic [FLOW_RAM_ADDR_WIDTH-1:0] addr  [DEPTH];
    logic [BYTES_WIDTH-1:0]         bytes [DEPTH];
    logic [FLOW_RAM_WORD_WIDTH-1:0] data  [DEPTH];
    logic [PW-1:0]                  alloc_ptr, ret_ptr, wb_ptr;

    // Alloc, fill and free always touch slots in different states, hence different indices.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                state[i] <= SLOT_FREE;
                addr[i]  <= '0;
                bytes[i] <= '0;
                data[i]  <= '0;
            end
            alloc_ptr <= '0;
            ret_ptr   <= '0;
            wb_ptr    <= '0;
            count     <= '0;
        end else begin
            if (alloc) begin
                state[alloc_ptr] <= SLOT_READ_WAIT;
                addr[alloc_ptr]  <= alloc_addr;
                bytes[alloc_ptr] <= alloc_bytes;
                alloc_ptr        <= alloc_ptr + 1'b1;
            end
            if (fill) begin
                state[ret_ptr] <= SLOT_WB_WAIT;
                data[ret_ptr]  <= fill_data;
                ret_ptr        <= ret_ptr + 1'b1;
            end
            if (free_slot) begin
                state[wb_ptr] <= SLOT_FREE;
                wb_ptr        <= wb_ptr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, alloc} - {{PW{1'b0}}, free_slot};
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (state[i] != SLOT_FREE && addr[i] == probe_addr) hazard = 1'b1;
        end
    end

    assign ret_pending = (state[ret_ptr] == SLOT_READ_WAIT);
    assign ret_addr    = addr[ret_ptr];
    assign ret_bytes   = bytes[ret_ptr];
    assign wb_pending  = (state[wb_ptr] == SLOT_WB_WAIT);
    assign wb_addr     = addr[wb_ptr];
    assign wb_data     = data[wb_ptr];

endmodule

// File: rtl/flow_rmw_engine.sv
// Flow RAM read-modify-write engine: SRAM handshakes, record update arithmetic
// and the registered updated-record output.
module flow_rmw_engine
    import flow_rmw_pkg::*;
#(
    parameter int PENDING_DEPTH = 16,
    parameter int BYTES_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           upd_valid,
    output logic                           upd_ready,
    input  logic [FLOW_RAM_ADDR_WIDTH-1:0] upd_addr,
    input  logic [BYTES_WIDTH-1:0]         upd_bytes,
    output logic                           sram_read_en,
    input  logic                           sram_read_ready,
    output logic [FLOW_RAM_ADDR_WIDTH-1:0] sram_read_addr,
    input  logic [FLOW_RAM_WORD_WIDTH-1:0] sram_read_data,
    input  logic                           sram_read_data_new,
    output logic                           sram_write_en,
    input  logic                           sram_write_ready,
    output logic [FLOW_RAM_ADDR_WIDTH-1:0] sram_write_addr,
    output logic [FLOW_RAM_WORD_WIDTH-1:0] sram_write_data,
    output logic                           out_valid,
    output logic [FLOW_RAM_ADDR_WIDTH-1:0] out_addr,
    output logic [FLOW_RAM_WORD_WIDTH-1:0] out_data,
    output logic [$clog2(PENDING_DEPTH):0] pending_count,
    output logic                           err_unexpected
);

    localparam int CW = $clog2(PENDING_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(PENDING_DEPTH);

    logic                           active, rd_blocked, wr_blocked;
    logic                           hazard, ret_pending, wb_pending;
    logic                           accept, ret_fire, wb_fire;
    logic [FLOW_RAM_ADDR_WIDTH-1:0] ret_addr, wb_addr;
    logic [BYTES_WIDTH-1:0]         ret_bytes;
    logic [FLOW_RAM_WORD_WIDTH-1:0] wb_data, new_word;

    flow_rmw_slot_table #(
        .DEPTH       (PENDING_DEPTH),
        .BYTES_WIDTH (BYTES_WIDTH)
    ) u_slots (
        .clk         (clk),
        .reset       (reset),
        .alloc       (accept),
        .alloc_addr  (upd_addr),
        .alloc_bytes (upd_bytes),
        .fill        (ret_fire),
        .fill_data   (new_word),
        .free_slot   (wb_fire),
        .probe_addr  (upd_addr),
        .hazard      (hazard),
        .count       (pending_count),
        .ret_pending (ret_pending),
        .ret_addr    (ret_addr),
        .ret_bytes   (ret_bytes),
        .wb_pending  (wb_pending),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    // 'active' holds acceptance off until the first clock after reset release.
    assign upd_ready = active & (pending_count < FULL) & ~rd_blocked & ~hazard;
    assign accept    = upd_valid & upd_ready;
    assign ret_fire  = sram_read_data_new & ret_pending;
    assign wb_fire   = wb_pending & ~wr_blocked;
    assign new_word  = flow_update(sram_read_data, FLOW_PKT_COUNT_WIDTH'(ret_bytes));

    assign sram_read_en    = accept;
    assign sram_read_addr  = accept ? upd_addr : '0;
    assign sram_write_en   = wb_fire;
    assign sram_write_addr = wb_fire ? wb_addr : '0;
    assign sram_write_data = wb_fire ? wb_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active         <= 1'b0;
            rd_blocked     <= 1'b0;
            wr_blocked     <= 1'b0;
            out_valid      <= 1'b0;
            out_addr       <= '0;
            out_data       <= '0;
            err_unexpected <= 1'b0;
        end else begin
            active     <= 1'b1;
            rd_blocked <= sram_read_en & ~sram_read_ready;
            wr_blocked <= sram_write_en & ~sram_write_ready;
            out_valid  <= ret_fire;
            if (ret_fire) begin
                out_addr <= ret_addr;
                out_data <= new_word;
            end
            if (sram_read_data_new & ~ret_pending) err_unexpected <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flow_rmw_engine.sv
// Randomized bench for flow_rmw_engine with an SRAM model and a record-level
// reference of expected flow counters, acceptance and write-back order.
module tb_flow_rmw_engine;
    import flow_rmw_pkg::*;

    localparam int D   = 16;
    localparam int BW  = 16;
    localparam int AW  = FLOW_RAM_ADDR_WIDTH;
    localparam int W   = FLOW_RAM_WORD_WIDTH;
    localparam int H   = W / 2;
    localparam int NA  = 1 << AW;
    localparam int LAT = 3;

    logic          clk, reset;
    logic          upd_valid, upd_ready;
    logic [AW-1:0] upd_addr;
    logic [BW-1:0] upd_bytes;
    logic          sram_read_en, sram_read_ready, sram_read_data_new;
    logic [AW-1:0] sram_read_addr;
    logic [W-1:0]  sram_read_data;
    logic          sram_write_en, sram_write_ready;
    logic [AW-1:0] sram_write_addr;
    logic [W-1:0]  sram_write_data;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [W-1:0]  out_data;
    logic [$clog2(D):0] pending_count;
    logic          err_unexpected;

    flow_rmw_engine #(.PENDING_DEPTH(D), .BYTES_WIDTH(BW)) dut (
        .clk(clk), .reset(reset),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_bytes(upd_bytes),
        .sram_read_en(sram_read_en), .sram_read_ready(sram_read_ready),
        .sram_read_addr(sram_read_addr), .sram_read_data(sram_read_data),
        .sram_read_data_new(sram_read_data_new),
        .sram_write_en(sram_write_en), .sram_write_ready(sram_write_ready),
        .sram_write_addr(sram_write_addr), .sram_write_data(sram_write_data),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
        .pending_count(pending_count), .err_unexpected(err_unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [BW-1:0] bytes; } upd_t;
    typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; } rec_t;
    typedef struct { int due; logic [W-1:0] data; } ret_t;

    logic [W-1:0] mem [NA];
    logic [W-1:0] ref_mem [NA];
    bit           busy [NA];
    upd_t acc_q[$];
    rec_t wb_q[$];
    ret_t ret_q[$];
    int   n_busy, n_rd_out, n_out, cyc;
    bit   prev_ret, rd_blk, wr_blk, live, err_m, last_acc;
    bit   rd_random, wr_random, rd_force_low, inject_stray;
    int   errors, checks;

    function automatic logic [W-1:0] ref_update(input logic [W-1:0] word, input logic [BW-1:0] b);
        longint unsigned max_v, pk, by;
        max_v = (64'd1 << H) - 64'd1;
        pk = word[H-1:0];
        pk = pk + 1;
        if (pk > max_v) pk = max_v;
        by = word[W-1:H];
        by = by + b;
        if (by > max_v) by = max_v;
        return {by[H-1:0], pk[H-1:0]};
    endfunction

    task automatic clear_model();
        acc_q.delete(); wb_q.delete(); ret_q.delete();
        for (int a = 0; a < NA; a++) busy[a] = 1'b0;
        n_busy = 0; n_rd_out = 0;
        prev_ret = 0; rd_blk = 0; wr_blk = 0; err_m = 0; live = 0;
        for (int a = 0; a < NA; a++) ref_mem[a] = mem[a];
    endtask

    // One clock cycle: drive SRAM inputs at the negedge, check settled outputs, advance.
    task automatic step();
        bit   got_ret, exp_ready, exp_rd, exp_wr, nxt_ret, nxt_err;
        upd_t u;
        rec_t r;
        logic [W-1:0] exp_w;
        sram_read_ready  = rd_force_low ? 1'b0 : (rd_random ? ($urandom_range(3) != 0) : 1'b1);
        rd_force_low     = 0;
        sram_write_ready = wr_random ? ($urandom_range(3) != 0) : 1'b1;
        sram_read_data_new = 1'b0;
        sram_read_data   = {$urandom, $urandom};
        got_ret = 0;
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            sram_read_data_new = 1'b1;
            sram_read_data     = ret_q[0].data;
            void'(ret_q.pop_front());
            got_ret = 1;
        end else if (inject_stray) begin
            sram_read_data_new = 1'b1;
            got_ret = 1;
        end
        inject_stray = 0;
        #1;
        exp_ready = live && (n_busy < D) && !rd_blk && !busy[upd_addr];
        checks++;
        if (upd_ready !== exp_ready) begin
            errors++; $display("FAIL upd_ready cyc %0d: got %b want %b", cyc, upd_ready, exp_ready);
        end
        checks++;
        if (pending_count !== n_busy[$clog2(D):0]) begin
            errors++; $display("FAIL pending_count cyc %0d: got %0d want %0d", cyc, pending_count, n_busy);
        end
        exp_rd = upd_valid && exp_ready;
        checks++;
        if (sram_read_en !== exp_rd) begin
            errors++; $display("FAIL sram_read_en cyc %0d: got %b want %b", cyc, sram_read_en, exp_rd);
        end
        checks++;
        if (err_unexpected !== err_m) begin
            errors++; $display("FAIL err_unexpected cyc %0d: got %b want %b", cyc, err_unexpected, err_m);
        end
        checks++;
        if (out_valid !== prev_ret) begin
            errors++; $display("FAIL out_valid cyc %0d: got %b want %b", cyc, out_valid, prev_ret);
        end
        if (out_valid === 1'b1 && acc_q.size() > 0) begin
            u = acc_q.pop_front();
            exp_w = ref_update(ref_mem[u.addr], u.bytes);
            ref_mem[u.addr] = exp_w;
            checks++;
            if (out_addr !== u.addr || out_data !== exp_w) begin
                errors++;
                $display("FAIL out_record cyc %0d: got %h/%h want %h/%h", cyc, out_addr, out_data, u.addr, exp_w);
            end
            wb_q.push_back('{u.addr, exp_w});
            n_out++;
        end
        exp_wr = (wb_q.size() > 0) && !wr_blk;
        checks++;
        if (sram_write_en !== exp_wr) begin
            errors++; $display("FAIL sram_write_en cyc %0d: got %b want %b", cyc, sram_write_en, exp_wr);
        end
        if (sram_write_en === 1'b1 && wb_q.size() > 0) begin
            r = wb_q.pop_front();
            checks++;
            if (sram_write_addr !== r.addr || sram_write_data !== r.data) begin
                errors++;
                $display("FAIL write cyc %0d: got %h/%h want %h/%h", cyc, sram_write_addr, sram_write_data, r.addr, r.data);
            end
            mem[sram_write_addr] = sram_write_data;
            busy[r.addr] = 1'b0;
            n_busy--;
        end
        nxt_ret = 0;
        nxt_err = err_m;
        if (got_ret) begin
            if (n_rd_out > 0) begin nxt_ret = 1; n_rd_out--; end
            else nxt_err = 1;
        end
        last_acc = (sram_read_en === 1'b1);
        if (last_acc) begin
            checks++;
            if (sram_read_addr !== upd_addr) begin
                errors++; $display("FAIL sram_read_addr cyc %0d: got %h want %h", cyc, sram_read_addr, upd_addr);
            end
            acc_q.push_back('{upd_addr, upd_bytes});
            ret_q.push_back('{cyc + LAT, mem[upd_addr]});
            busy[upd_addr] = 1'b1;
            n_busy++;
            n_rd_out++;
        end
        rd_blk   = sram_read_en && !sram_read_ready;
        wr_blk   = sram_write_en && !sram_write_ready;
        prev_ret = nxt_ret;
        err_m    = nxt_err;
        @(posedge clk);
        live = 1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b, output int waited);
        upd_valid = 1'b1; upd_addr = a; upd_bytes = b; waited = 0;
        do begin step(); waited++; end while (!last_acc && waited < 100);
        upd_valid = 1'b0;
        checks++;
        if (!last_acc) begin errors++; $display("FAIL send_timeout addr %h: got no accept want accept", a); end
    endtask

    task automatic drain();
        int n;
        upd_valid = 1'b0;
        n = 0;
        while ((n_busy != 0 || ret_q.size() != 0 || wb_q.size() != 0 || prev_ret) && n < 400) begin
            step(); n++;
        end
        checks++;
        if (n_busy != 0) begin errors++; $display("FAIL drain_timeout: got %0d busy want 0", n_busy); end
    endtask

    task automatic test_reset();
        upd_valid = 1'b1; upd_addr = 8'h05; upd_bytes = 16'd7;
        #1;
        checks++;
        if ({upd_ready, sram_read_en, sram_write_en, out_valid, err_unexpected} !== 5'b0 ||
            pending_count !== '0 || sram_read_addr !== '0 || out_data !== '0 || out_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b rd=%b wr=%b ov=%b err=%b cnt=%0d want all 0",
                     upd_ready, sram_read_en, sram_write_en, out_valid, err_unexpected, pending_count);
        end
        upd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(); step();
    endtask

    task automatic test_single();
        int w;
        mem[8'h10] = '0; ref_mem[8'h10] = '0;
        send(8'h10, 16'd100, w);
        drain();
        checks++;
        if (mem[8'h10] !== {32'd100, 32'd1}) begin
            errors++; $display("FAIL single_record: got %h want %h", mem[8'h10], {32'd100, 32'd1});
        end
        checks++;
        if (pending_count !== '0) begin errors++; $display("FAIL single_count: got %0d want 0", pending_count); end
    endtask

    task automatic test_stream();
        int out0;
        out0 = n_out;
        for (int i = 0; i < 64; i++) begin
            upd_valid = 1'b1; upd_addr = AW'(8'h40 + i); upd_bytes = BW'($urandom);
            step();
            checks++;
            if (!last_acc) begin errors++; $display("FAIL stream_accept %0d: got stall want accept", i); end
        end
        drain();
        checks++;
        if (n_out - out0 != 64) begin errors++; $display("FAIL stream_outputs: got %0d want 64", n_out - out0); end
    endtask

    task automatic test_same_addr();
        int w;
        logic [BW-1:0] b1, b2;
        b1 = BW'($urandom); b2 = BW'($urandom);
        mem[8'h20] = '0; ref_mem[8'h20] = '0;
        send(8'h20, b1, w);
        send(8'h20, b2, w);
        checks++;
        if (w != LAT + 2) begin errors++; $display("FAIL same_addr_gap: got %0d want %0d", w, LAT + 2); end
        drain();
        checks++;
        if (mem[8'h20] !== {H'(b1) + H'(b2), 32'd2}) begin
            errors++; $display("FAIL same_addr_record: got %h want %h", mem[8'h20], {H'(b1) + H'(b2), 32'd2});
        end
    endtask

    task automatic test_read_block();
        int sent, n;
        sent = 0; n = 0;
        while (sent < 8 && n < 40) begin
            upd_valid = 1'b1; upd_addr = AW'(8'h90 + sent); upd_bytes = BW'($urandom);
            if (n == 2) rd_force_low = 1;
            step(); n++;
            if (last_acc) sent++;
        end
        upd_valid = 1'b0;
        checks++;
        if (n != 9) begin errors++; $display("FAIL read_block_cycles: got %0d want 9", n); end
        drain();
    endtask

    task automatic test_saturate();
        int w;
        mem[8'h30] = '1;
        mem[8'h31] = {32'hFFFF_FFFD, 32'hFFFF_FFFF};
        mem[8'h32] = {32'h0, 32'hFFFF_FFFE};
        for (int a = 8'h30; a <= 8'h32; a++) ref_mem[a] = mem[a];
        send(8'h30, 16'd5, w);
        send(8'h31, 16'd5, w);
        send(8'h32, 16'd0, w);
        drain();
        checks++;
        if (mem[8'h30] !== {64{1'b1}}) begin errors++; $display("FAIL sat_both: got %h want all ones", mem[8'h30]); end
        checks++;
        if (mem[8'h31] !== {64{1'b1}}) begin errors++; $display("FAIL sat_bytes: got %h want all ones", mem[8'h31]); end
        checks++;
        if (mem[8'h32] !== {32'h0, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL sat_pkts: got %h want %h", mem[8'h32], {32'h0, 32'hFFFF_FFFF});
        end
    endtask

    task automatic test_random();
        rd_random = 1; wr_random = 1;
        for (int i = 0; i < 400; i++) begin
            upd_valid = ($urandom_range(9) < 7);
            upd_addr  = AW'(8'hA0 + $urandom_range(15));
            upd_bytes = ($urandom_range(7) == 0) ? 16'hFFFF : BW'($urandom);
            step();
        end
        drain();
        rd_random = 0; wr_random = 0;
        drain();
        for (int a = 0; a < NA; a++) begin
            checks++;
            if (mem[a] !== ref_mem[a]) begin
                errors++; $display("FAIL random_mem[%0h]: got %h want %h", a, mem[a], ref_mem[a]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 10; i++) begin
            upd_valid = 1'b1; upd_addr = AW'(8'hC0 + i); upd_bytes = BW'($urandom);
            step();
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({upd_ready, sram_read_en, sram_write_en, out_valid, err_unexpected} !== 5'b0 ||
            pending_count !== '0 || out_data !== '0 || out_addr !== '0 || sram_write_data !== '0) begin
            errors++;
            $display("FAIL midflight_reset: got rdy=%b rd=%b wr=%b ov=%b cnt=%0d want all 0",
                     upd_ready, sram_read_en, sram_write_en, out_valid, pending_count);
        end
        clear_model();
        upd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(); step(); step();
        inject_stray = 1;
        step(); step();
        checks++;
        if (err_unexpected !== 1'b1) begin
            errors++; $display("FAIL stray_return: got %b want 1", err_unexpected);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0; cyc = 0; n_out = 0;
        rd_random = 0; wr_random = 0; rd_force_low = 0; inject_stray = 0;
        upd_valid = 1'b0; upd_addr = '0; upd_bytes = '0;
        sram_read_ready = 1'b1; sram_write_ready = 1'b1;
        sram_read_data_new = 1'b0; sram_read_data = '0;
        for (int a = 0; a < NA; a++) mem[a] = {$urandom, $urandom};
        clear_model();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_stream();
        test_same_addr();
        test_read_block();
        test_saturate();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
